// File: rtl/regfile_32b.sv
// regfile_32b
//   Integer register file for the ALU datapath: 32 x XLEN registers, x0
//   hardwired to zero, two combinational operand read ports, one debug read
//   port and one write-back port. Writes land in a one-entry pending slot
//   that commits to the array on the following edge. The slot is forwarded
//   to every read port, so a write is visible one edge after it is issued.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   rs1_addr  in   read port 0 address
//   rs2_addr  in   read port 1 address
//   out0      out  read port 0 data (ALU in0)
//   out1      out  read port 1 data (ALU in1)
//   wr_en     in   write request
//   wr_addr   in   write destination register
//   wr_data   in   write data (ALU out)
//   dbg_addr  in   debug read address
//   dbg_out   out  debug read data
module regfile_32b #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] out0,
    output logic [XLEN-1:0] out1,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_out
);

    // x0 has no storage.
    logic [XLEN-1:0] regs [1:NREGS-1];

    logic            pend_vld;
    logic [AW-1:0]   pend_addr;
    logic [XLEN-1:0] pend_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            // The slot only ever holds a non-zero address; the extra compare
            // keeps the array index in range.
            if (pend_vld && (pend_addr != '0)) begin
                regs[pend_addr] <= pend_data;
            end
            if (wr_en && (wr_addr != '0)) begin
                pend_vld  <= 1'b1;
                pend_addr <= wr_addr;
                pend_data <= wr_data;
            end else begin
                pend_vld  <= 1'b0;
            end
        end
    end

    // Pending slot wins over the array so back-to-back writes to one register
    // always read back the newest value.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
        if (a == '0) begin
            return '0;
        end else if (pend_vld && (pend_addr == a)) begin
            return pend_data;
        end else begin
            return regs[a];
        end
    endfunction

    assign out0    = read_port(rs1_addr);
    assign out1    = read_port(rs2_addr);
    assign dbg_out = read_port(dbg_addr);

endmodule

// File: tb/tb_regfile_32b.sv
module tb_regfile_32b;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] out0;
    logic [31:0] out1;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_out;

    int vec_cnt;
    int err_cnt;

    regfile_32b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .out0     (out0),
        .out1     (out1),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_out  (dbg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        rst_n    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        dbg_addr = '0;
        wr(5'd5, 32'hDEAD_BEEF);

        // reset with a write request pending
        tick();
        tick();
        rst_n = 1'b1;
        wr_en = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(a);
            dbg_addr = 5'(a);
            #1;
            chk($sformatf("rst_out0_x%0d", a), out0, 32'h0);
            chk($sformatf("rst_out1_x%0d", a), out1, 32'h0);
            chk($sformatf("rst_dbg_x%0d", a), dbg_out, 32'h0);
        end

        // incoming data not forwarded before the edge
        rs1_addr = 5'd3;
        rs2_addr = 5'd3;
        wr(5'd3, 32'h0000_0007);
        #1;
        chk("x3_pre_edge", out0, 32'h0);
        tick();
        wr_en = 1'b0;
        chk("x3_fwd_out0", out0, 32'h7);
        chk("x3_fwd_out1", out1, 32'h7);
        tick();
        chk("x3_arr_out0", out0, 32'h7);
        chk("x3_arr_out1", out1, 32'h7);

        // x0 writes discarded
        rs1_addr = 5'd0;
        wr(5'd0, 32'hFFFF_FFFF);
        tick();
        wr_en = 1'b0;
        chk("x0_read", out0, 32'h0);
        chk("x0_pend_vld", {31'h0, dut.pend_vld}, 32'h0);
        tick();
        chk("x0_read_late", out0, 32'h0);

        // back-to-back to one register
        rs1_addr = 5'd7;
        dbg_addr = 5'd7;
        wr(5'd7, 32'd1);
        tick();
        chk("x7_b2b_1", out0, 32'd1);
        chk("x7_b2b_1_dbg", dbg_out, 32'd1);
        wr(5'd7, 32'd2);
        tick();
        chk("x7_b2b_2", out0, 32'd2);
        chk("x7_b2b_2_dbg", dbg_out, 32'd2);
        wr(5'd7, 32'd3);
        tick();
        chk("x7_b2b_3", out0, 32'd3);
        chk("x7_b2b_3_dbg", dbg_out, 32'd3);
        wr_en = 1'b0;
        tick();
        chk("x7_idle_1", out0, 32'd3);
        tick();
        chk("x7_idle_2", dbg_out, 32'd3);

        // interleaved: one operand from array, one forwarded
        rs1_addr = 5'd1;
        rs2_addr = 5'd2;
        wr(5'd1, 32'd10);
        tick();
        wr(5'd2, 32'd20);
        tick();
        wr_en = 1'b0;
        chk("intl_out0", out0, 32'd10);
        chk("intl_out1", out1, 32'd20);
        chk("intl_sum", out0 + out1, 32'd30);
        dbg_addr = 5'd3;
        #1;
        chk("x3_retained", dbg_out, 32'h7);

        // reset while a write sits in the pending slot
        rs1_addr = 5'd9;
        wr(5'd9, 32'h0000_1234);
        tick();
        chk("x9_fwd", out0, 32'h1234);
        wr_en = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("x9_after_rst", out0, 32'h0);
        rs2_addr = 5'd7;
        dbg_addr = 5'd3;
        #1;
        chk("x7_after_rst", out1, 32'h0);
        chk("x3_after_rst", dbg_out, 32'h0);
        tick();
        chk("x9_after_rst_late", out0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
